// File: rtl/ahb_ecc_sram_responder_if.sv
// AHB-Lite bus bundle between the LSU data-bus initiator and the ECC SRAM responder.
interface ahb_ecc_sram_responder_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [5:0]  hparity;
    logic [31:0] hwdata;
    logic [6:0]  hwdcheck;
    logic [31:0] hrdata;
    logic [6:0]  hrdcheck;
    logic        hready;
    logic        hresp;

    modport master (
        output hsel, haddr, htrans, hsize, hwrite, hparity, hwdata, hwdcheck,
        input  hrdata, hrdcheck, hready, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hsize, hwrite, hparity, hwdata, hwdcheck,
        output hrdata, hrdcheck, hready, hresp
    );
endinterface

// File: rtl/ahb_ecc_sram_responder.sv
// AHB-Lite SRAM responder: 32-bit data + 7-bit SECDED check per word, address/control
// parity checking, optional wait states and a two-cycle ERROR response.
module ahb_ecc_sram_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 0,
    parameter int PAR_CHECK   = 1
) (
    input  logic                           s_clk_i,
    input  logic                           s_resetn_i,
    ahb_ecc_sram_responder_if.slave        bus,
    output logic [7:0]                     s_errcnt_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_ACC  = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

    // Hamming(38,32) with an overall parity bit on top; data bits fill the
    // non-power-of-two codeword positions 3,5,6,7,9,... in ascending order.
    function automatic logic [6:0] secded_encode(input logic [31:0] data);
        logic [6:0] chk;
        int         di;
        chk = 7'd0;
        di  = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                for (int b = 0; b < 6; b++) begin
                    if (((pos >> b) & 1) != 0) begin
                        chk[b] = chk[b] ^ data[di[4:0]];
                    end else begin
                        chk[b] = chk[b];
                    end
                end
                di = di + 1;
            end else begin
                di = di;
            end
        end
        chk[6] = (^data) ^ (^chk[5:0]);
        return chk;
    endfunction

    // Expected initiator parity: odd parity per address byte, plain xor for control.
    function automatic logic [5:0] addr_parity(input logic [31:0] addr,
                                               input logic [2:0]  size,
                                               input logic        write,
                                               input logic [1:0]  trans);
        logic [5:0] par;
        for (int k = 0; k < 4; k++) begin
            par[k] = ~(^addr[8*k +: 8]);
        end
        par[4] = (^size) ^ write;
        par[5] = ^trans;
        return par;
    endfunction

    logic [31:0]           mem_data_q [DEPTH];
    logic [6:0]            mem_chk_q  [DEPTH];

    logic [2:0]            state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [1:0]            lane_q;
    logic [1:0]            size_q;
    logic                  write_q;
    logic                  hready_q, hready_d;
    logic                  hresp_q, hresp_d;
    logic [31:0]           hrdata_q, hrdata_d;
    logic [6:0]            hrdchk_q, hrdchk_d;
    logic [7:0]            errcnt_q, errcnt_d;

    logic                  accept_s;
    logic                  par_err_s;
    logic                  size_err_s;
    logic                  align_err_s;
    logic                  range_err_s;
    logic                  addr_err_s;
    logic [DEPTH_LOG2-1:0] nxt_idx_s;
    logic                  nxt_write_s;
    logic                  commit_s;
    logic [31:0]           wr_data_s;
    logic [6:0]            wr_chk_s;

    // Address-phase acceptance and error classification of the presented transfer.
    always_comb begin
        accept_s    = bus.hsel & bus.htrans[1] & hready_q;
        if (PAR_CHECK != 0) begin
            par_err_s = (bus.hparity != addr_parity(bus.haddr, bus.hsize, bus.hwrite, bus.htrans));
        end else begin
            par_err_s = 1'b0;
        end
        size_err_s  = (bus.hsize > 3'd2);
        align_err_s = ((bus.hsize == 3'd1) && bus.haddr[0]) ||
                      ((bus.hsize == 3'd2) && (bus.haddr[1:0] != 2'b00));
        range_err_s = |bus.haddr[31:DEPTH_LOG2+2];
        addr_err_s  = par_err_s | size_err_s | align_err_s | range_err_s;
        if (accept_s) begin
            nxt_idx_s   = bus.haddr[DEPTH_LOG2+1:2];
            nxt_write_s = bus.hwrite;
        end else begin
            nxt_idx_s   = idx_q;
            nxt_write_s = write_q;
        end
    end

    // Write merge: sub-word writes re-encode the merged word, full-word writes keep the
    // initiator's check bits untouched so end-to-end corruption stays visible.
    always_comb begin
        commit_s  = (state_q == ST_ACC) && write_q;
        wr_data_s = mem_data_q[idx_q];
        case (size_q)
            2'd0: begin
                wr_data_s[8*lane_q +: 8] = bus.hwdata[8*lane_q +: 8];
                wr_chk_s                 = secded_encode(wr_data_s);
            end
            2'd1: begin
                wr_data_s[16*lane_q[1] +: 16] = bus.hwdata[16*lane_q[1] +: 16];
                wr_chk_s                      = secded_encode(wr_data_s);
            end
            default: begin
                wr_data_s = bus.hwdata;
                wr_chk_s  = bus.hwdcheck;
            end
        endcase
    end

    // Transfer FSM next state and wait-state counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_ACC, ST_ERR2: begin
                if (accept_s && addr_err_s) begin
                    state_d = ST_ERR1;
                end else if (accept_s && (WAIT_STATES > 0)) begin
                    state_d = ST_WAIT;
                    cnt_d   = 3'(WAIT_STATES);
                end else if (accept_s) begin
                    state_d = ST_ACC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 3'd1) begin
                    state_d = ST_ACC;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered response values for the coming cycle; a read right behind a write to
    // the same word sees the word being committed on this edge.
    always_comb begin
        hready_d = (state_d == ST_IDLE) || (state_d == ST_ACC) || (state_d == ST_ERR2);
        hresp_d  = (state_d == ST_ERR1) || (state_d == ST_ERR2);
        hrdata_d = 32'd0;
        hrdchk_d = 7'd0;
        if ((state_d == ST_ACC) && !nxt_write_s) begin
            if (commit_s && (idx_q == nxt_idx_s)) begin
                hrdata_d = wr_data_s;
                hrdchk_d = wr_chk_s;
            end else begin
                hrdata_d = mem_data_q[nxt_idx_s];
                hrdchk_d = mem_chk_q[nxt_idx_s];
            end
        end else begin
            hrdata_d = 32'd0;
            hrdchk_d = 7'd0;
        end
        if ((state_q == ST_ERR1) && (errcnt_q != 8'hFF)) begin
            errcnt_d = errcnt_q + 8'd1;
        end else begin
            errcnt_d = errcnt_q;
        end
    end

    // FSM, captured address-phase fields and response registers.
    always_ff @(posedge s_clk_i) begin
        if (!s_resetn_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            idx_q    <= '0;
            lane_q   <= 2'd0;
            size_q   <= 2'd0;
            write_q  <= 1'b0;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
            hrdata_q <= 32'd0;
            hrdchk_q <= 7'd0;
            errcnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= nxt_idx_s;
            write_q  <= nxt_write_s;
            if (accept_s) begin
                lane_q <= bus.haddr[1:0];
                size_q <= bus.hsize[1:0];
            end else begin
                lane_q <= lane_q;
                size_q <= size_q;
            end
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
            hrdata_q <= hrdata_d;
            hrdchk_q <= hrdchk_d;
            errcnt_q <= errcnt_d;
        end
    end

    // Array write port; no reset on the array, and a write in flight when reset hits is dropped.
    always_ff @(posedge s_clk_i) begin
        if (commit_s && s_resetn_i) begin
            mem_data_q[idx_q] <= wr_data_s;
            mem_chk_q[idx_q]  <= wr_chk_s;
        end
    end

    assign bus.hrdata   = hrdata_q;
    assign bus.hrdcheck = hrdchk_q;
    assign bus.hready   = hready_q;
    assign bus.hresp    = hresp_q;
    assign s_errcnt_o   = errcnt_q;

endmodule

// File: tb/tb_ahb_ecc_sram_responder.sv
// Directed bench: one responder with no wait states, one with two, sharing the stimulus bus.
module tb_ahb_ecc_sram_responder;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sel = 1'b0;          // 0: zero-wait DUT, 1: two-wait DUT
    logic        hsel = 1'b0;
    logic [31:0] haddr = 32'd0;
    logic [1:0]  htrans = 2'd0;
    logic [2:0]  hsize = 3'd0;
    logic        hwrite = 1'b0;
    logic [5:0]  hparity = 6'd0;
    logic [31:0] hwdata = 32'd0;
    logic [6:0]  hwdcheck = 7'd0;
    logic [7:0]  errcnt0, errcnt2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ahb_ecc_sram_responder_if bus0();
    ahb_ecc_sram_responder_if bus2();

    assign bus0.hsel = hsel & ~sel;   assign bus2.hsel = hsel & sel;
    assign bus0.haddr = haddr;        assign bus2.haddr = haddr;
    assign bus0.htrans = htrans;      assign bus2.htrans = htrans;
    assign bus0.hsize = hsize;        assign bus2.hsize = hsize;
    assign bus0.hwrite = hwrite;      assign bus2.hwrite = hwrite;
    assign bus0.hparity = hparity;    assign bus2.hparity = hparity;
    assign bus0.hwdata = hwdata;      assign bus2.hwdata = hwdata;
    assign bus0.hwdcheck = hwdcheck;  assign bus2.hwdcheck = hwdcheck;

    ahb_ecc_sram_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0), .PAR_CHECK(1)) dut0 (
        .s_clk_i(clk), .s_resetn_i(resetn), .bus(bus0), .s_errcnt_o(errcnt0));
    ahb_ecc_sram_responder #(.DEPTH_LOG2(10), .WAIT_STATES(2), .PAR_CHECK(1)) dut2 (
        .s_clk_i(clk), .s_resetn_i(resetn), .bus(bus2), .s_errcnt_o(errcnt2));

    wire [31:0] rdata  = sel ? bus2.hrdata   : bus0.hrdata;
    wire [6:0]  rchk   = sel ? bus2.hrdcheck : bus0.hrdcheck;
    wire        rdy    = sel ? bus2.hready   : bus0.hready;
    wire        rsp    = sel ? bus2.hresp    : bus0.hresp;
    wire [7:0]  errcnt = sel ? errcnt2       : errcnt0;

    // Reference SECDED: build the 38-bit Hamming codeword explicitly, then take masked parities.
    function automatic logic [6:0] ref_encode(input logic [31:0] d);
        logic [38:0] cw;
        logic [38:0] mask;
        logic [6:0]  c;
        int          k;
        cw = 39'd0;
        k  = 0;
        for (int p = 1; p <= 38; p++) begin
            if (p != 1 && p != 2 && p != 4 && p != 8 && p != 16 && p != 32) begin
                cw[p] = d[k];
                k++;
            end
        end
        for (int b = 0; b < 6; b++) begin
            mask = 39'd0;
            for (int p = 1; p <= 38; p++) mask[p] = ((p / (1 << b)) % 2) == 1;
            c[b] = ^(cw & mask);
        end
        c[6] = (^d) ^ (^c[5:0]);
        return c;
    endfunction

    function automatic logic [5:0] ref_parity(input logic [31:0] a, input logic [2:0] s,
                                              input logic w, input logic [1:0] t);
        logic [5:0] p;
        p[0] = ~(^a[7:0]);   p[1] = ~(^a[15:8]);
        p[2] = ~(^a[23:16]); p[3] = ~(^a[31:24]);
        p[4] = s[0] ^ s[1] ^ s[2] ^ w;
        p[5] = t[0] ^ t[1];
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_addr(input logic [31:0] a, input logic [2:0] s, input logic w, input bit badpar);
        hsel    = 1'b1;
        htrans  = 2'b10;
        haddr   = a;
        hsize   = s;
        hwrite  = w;
        hparity = ref_parity(a, s, w, 2'b10) ^ {5'd0, badpar};
    endtask

    task automatic drive_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
    endtask

    // One non-pipelined transfer, starting right after an active edge.
    task automatic xfer(input string nm, input bit wr, input logic [31:0] a, input logic [2:0] s,
                        input logic [31:0] wd, input logic [6:0] wc, input bit badpar,
                        input bit experr, input logic [31:0] erd, input logic [6:0] erc,
                        input int ws);
        drive_addr(a, s, wr, badpar);
        step();
        drive_idle();
        hwdata   = wd;
        hwdcheck = wc;
        if (experr) begin
            chk({nm, "_err1_ready"}, rdy, 1'b0);
            chk({nm, "_err1_resp"}, rsp, 1'b1);
            step();
            chk({nm, "_err2_ready"}, rdy, 1'b1);
            chk({nm, "_err2_resp"}, rsp, 1'b1);
            step();
            chk({nm, "_after_resp"}, rsp, 1'b0);
        end else begin
            for (int i = 0; i < ws; i++) begin
                chk({nm, "_wait_ready"}, rdy, 1'b0);
                step();
            end
            chk({nm, "_ready"}, rdy, 1'b1);
            chk({nm, "_resp"}, rsp, 1'b0);
            if (!wr) begin
                chk({nm, "_rdata"}, rdata, erd);
                chk({nm, "_rchk"}, {25'd0, rchk}, {25'd0, erc});
            end
            step();
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [6:0]  wchk;
        bit          badpar;
        bit          experr;
        logic [31:0] erd;
        logic [6:0]  erc;
    } vec_t;

    vec_t tv [19];

    initial begin
        tv[0]  = '{1'b1, 32'h10,   3'd2, 32'hDEADBEEF, 7'h5A, 1'b0, 1'b0, 32'h0, 7'h0};
        tv[1]  = '{1'b0, 32'h10,   3'd2, 32'h0,        7'h0,  1'b0, 1'b0, 32'hDEADBEEF, 7'h5A};
        tv[2]  = '{1'b1, 32'h10,   3'd2, 32'h11223344, 7'h33, 1'b0, 1'b0, 32'h0, 7'h0};
        tv[3]  = '{1'b1, 32'h11,   3'd0, 32'h0000AB00, 7'h00, 1'b0, 1'b0, 32'h0, 7'h0};
        tv[4]  = '{1'b0, 32'h10,   3'd2, 32'h0,        7'h0,  1'b0, 1'b0, 32'h1122AB44, ref_encode(32'h1122AB44)};
        tv[5]  = '{1'b1, 32'h14,   3'd2, 32'hCAFEF00D, 7'h11, 1'b0, 1'b0, 32'h0, 7'h0};
        tv[6]  = '{1'b1, 32'h16,   3'd1, 32'h12340000, 7'h00, 1'b0, 1'b0, 32'h0, 7'h0};
        tv[7]  = '{1'b0, 32'h14,   3'd2, 32'h0,        7'h0,  1'b0, 1'b0, 32'h1234F00D, ref_encode(32'h1234F00D)};
        tv[8]  = '{1'b1, 32'h17,   3'd0, 32'h99000000, 7'h00, 1'b0, 1'b0, 32'h0, 7'h0};
        tv[9]  = '{1'b0, 32'h14,   3'd2, 32'h0,        7'h0,  1'b0, 1'b0, 32'h9934F00D, ref_encode(32'h9934F00D)};
        tv[10] = '{1'b1, 32'h10,   3'd2, 32'h00000000, 7'h00, 1'b1, 1'b1, 32'h0, 7'h0};
        tv[11] = '{1'b0, 32'h10,   3'd2, 32'h0,        7'h0,  1'b0, 1'b0, 32'h1122AB44, ref_encode(32'h1122AB44)};
        tv[12] = '{1'b1, 32'h13,   3'd1, 32'hFFFFFFFF, 7'h00, 1'b0, 1'b1, 32'h0, 7'h0};
        tv[13] = '{1'b0, 32'h1000, 3'd2, 32'h0,        7'h0,  1'b0, 1'b1, 32'h0, 7'h0};
        tv[14] = '{1'b0, 32'h20,   3'd3, 32'h0,        7'h0,  1'b0, 1'b1, 32'h0, 7'h0};
        tv[15] = '{1'b0, 32'h12,   3'd2, 32'h0,        7'h0,  1'b0, 1'b1, 32'h0, 7'h0};
        tv[16] = '{1'b1, 32'hFFC,  3'd2, 32'h0BADF00D, 7'h7F, 1'b0, 1'b0, 32'h0, 7'h0};
        tv[17] = '{1'b0, 32'hFFC,  3'd2, 32'h0,        7'h0,  1'b0, 1'b0, 32'h0BADF00D, 7'h7F};
        tv[18] = '{1'b0, 32'h10,   3'd0, 32'h0,        7'h0,  1'b0, 1'b0, 32'h1122AB44, ref_encode(32'h1122AB44)};

        // Reset state of both responders
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            sel = (d == 1);
            #1;
            chk($sformatf("rst%0d_ready", d), rdy, 1'b1);
            chk($sformatf("rst%0d_resp", d), rsp, 1'b0);
            chk($sformatf("rst%0d_rdata", d), rdata, 32'd0);
            chk($sformatf("rst%0d_errcnt", d), errcnt, 8'd0);
        end
        sel = 1'b0;
        resetn = 1'b1;
        step();

        // Table of single transfers on the zero-wait responder
        for (int i = 0; i < 19; i++) begin
            xfer($sformatf("v%0d", i), tv[i].wr, tv[i].addr, tv[i].size, tv[i].wdata, tv[i].wchk,
                 tv[i].badpar, tv[i].experr, tv[i].erd, tv[i].erc, 0);
        end
        chk("errcnt_after_table", errcnt, 8'd5);

        // Pipelined write then read of the same word: read sees the new data
        drive_addr(32'h20, 3'd2, 1'b1, 1'b0);
        step();
        hwdata   = 32'h13579BDF;
        hwdcheck = 7'h44;
        drive_addr(32'h20, 3'd2, 1'b0, 1'b0);
        step();
        drive_idle();
        chk("wr_rd_fwd_rdata", rdata, 32'h13579BDF);
        chk("wr_rd_fwd_rchk", {25'd0, rchk}, 32'h44);
        step();
        chk("wr_rd_idle_rdata", rdata, 32'd0);

        // Back-to-back erroring transfers saturate the error counter
        drive_addr(32'h1000, 3'd2, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step();
            step();
        end
        drive_idle();
        step();
        chk("sat_errcnt", errcnt, 8'd255);
        chk("sat_ready", rdy, 1'b1);
        chk("sat_resp", rsp, 1'b0);

        // Two-wait responder: writes, then pipelined reads of 0x10 and 0x14
        sel = 1'b1;
        xfer("ws_w10", 1'b1, 32'h10, 3'd2, 32'hA5A50F0F, 7'h2C, 1'b0, 1'b0, 32'h0, 7'h0, 2);
        xfer("ws_w14", 1'b1, 32'h14, 3'd2, 32'h5A5AF0F0, 7'h13, 1'b0, 1'b0, 32'h0, 7'h0, 2);
        drive_addr(32'h10, 3'd2, 1'b0, 1'b0);
        step();
        chk("pipe_a_wait1", rdy, 1'b0);
        step();
        chk("pipe_a_wait2", rdy, 1'b0);
        step();
        chk("pipe_a_ready", rdy, 1'b1);
        chk("pipe_a_rdata", rdata, 32'hA5A50F0F);
        chk("pipe_a_rchk", {25'd0, rchk}, 32'h2C);
        drive_addr(32'h14, 3'd2, 1'b0, 1'b0);
        step();
        drive_idle();
        chk("pipe_b_wait1", rdy, 1'b0);
        step();
        chk("pipe_b_wait2", rdy, 1'b0);
        step();
        chk("pipe_b_ready", rdy, 1'b1);
        chk("pipe_b_rdata", rdata, 32'h5A5AF0F0);
        chk("pipe_b_rchk", {25'd0, rchk}, 32'h13);
        step();

        // Parity error on the two-wait responder counts once
        xfer("ws_par", 1'b1, 32'h10, 3'd2, 32'h0, 7'h0, 1'b1, 1'b1, 32'h0, 7'h0, 2);
        chk("ws_errcnt", errcnt, 8'd1);

        // Reset during the wait of a write: write dropped, outputs back to reset values
        drive_addr(32'h10, 3'd2, 1'b1, 1'b0);
        step();
        chk("rstw_wait", rdy, 1'b0);
        drive_idle();
        hwdata   = 32'hFFFFFFFF;
        hwdcheck = 7'h7F;
        resetn   = 1'b0;
        step();
        chk("rstw_ready", rdy, 1'b1);
        chk("rstw_resp", rsp, 1'b0);
        chk("rstw_errcnt", errcnt, 8'd0);
        resetn = 1'b1;
        step();
        step();
        xfer("rstw_rd", 1'b0, 32'h10, 3'd2, 32'h0, 7'h0, 1'b0, 1'b0, 32'hA5A50F0F, 7'h2C, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
